// File: rtl/burst_rd_pkg.sv
// Shared types and constants for the Avalon-MM burst read master.
// Holds the FSM state encoding, default geometry and the address-step helper.
package burst_rd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        REQ   = 3'd2,
        DATA  = 3'd3,
        DONE  = 3'd4
    } rd_state_e;

    localparam int DEF_ADDRESS_WIDTH     = 32;
    localparam int DEF_DATA_WIDTH        = 32;
    localparam int DEF_BYTE_ENABLE_WIDTH = 4;
    localparam int DEF_BURST_WIDTH       = 4;
    localparam int DEF_LENGTH_WIDTH      = 16;
    localparam int DEF_FIFO_DEPTH        = 16;
    localparam int DEF_FIFO_DEPTH_LOG2   = 4;

    // Byte distance between consecutive burst start addresses.
    function automatic logic [31:0] addr_incr(input logic [31:0] burst,
                                              input logic [31:0] bytes_per_word);
        return burst * bytes_per_word;
    endfunction

endpackage

// File: rtl/burst_read_wf_if.sv
// Avalon-MM read bus between the burst read master and the memory bridge.
// The master modport is used by burst_read_wf; the slave modport by the memory side.
interface burst_read_wf_if
    import burst_rd_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int BYTE_ENABLE_WIDTH = DEF_BYTE_ENABLE_WIDTH,
    parameter int BURST_WIDTH       = DEF_BURST_WIDTH
);
    logic [ADDRESS_WIDTH-1:0]     master_address;
    logic                         master_read;
    logic [BURST_WIDTH-1:0]       master_burstcount;
    logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable;
    logic                         master_waitrequest;
    logic [DATA_WIDTH-1:0]        master_readdata;
    logic                         master_readdatavalid;

    modport master (
        output master_address, master_read, master_burstcount, master_byteenable,
        input  master_waitrequest, master_readdata, master_readdatavalid
    );

    modport slave (
        input  master_address, master_read, master_burstcount, master_byteenable,
        output master_waitrequest, master_readdata, master_readdatavalid
    );
endinterface

// File: rtl/burst_rd_fifo.sv
// Show-ahead synchronous FIFO: head word is visible whenever not_empty is high.
// Exposes its fill level so the requester can wait for room for a whole burst.
module burst_rd_fifo
    import burst_rd_pkg::*;
#(
    parameter int WIDTH      = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_FIFO_DEPTH,
    parameter int DEPTH_LOG2 = DEF_FIFO_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_data,
    output logic                  not_empty,
    output logic [DEPTH_LOG2:0]   level
);
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   level_r;
    logic                  not_empty_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;
    logic [DEPTH_LOG2:0]   level_next_s;

    // Qualify push/pop against full/empty and compute the next fill level.
    always_comb begin
        push_ok_s    = push && (level_r != LVL_FULL);
        pop_ok_s     = pop && (level_r != {(DEPTH_LOG2 + 1){1'b0}});
        level_next_s = level_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_next_s = level_r + LVL_ONE;
            2'b01:   level_next_s = level_r - LVL_ONE;
            default: level_next_s = level_r;
        endcase
    end

    // Storage, pointers and level registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r    <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r    <= {DEPTH_LOG2{1'b0}};
            level_r     <= {(DEPTH_LOG2 + 1){1'b0}};
            not_empty_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r     <= level_next_s;
            not_empty_r <= (level_next_s != {(DEPTH_LOG2 + 1){1'b0}});
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign not_empty = not_empty_r;
    assign level     = level_r;

endmodule

// File: rtl/burst_read_wf.sv
// Avalon-MM burst read master: fetches ctrl_length bursts of ctrl_burstcount words
// from consecutive addresses and streams them out through a show-ahead FIFO.
module burst_read_wf
    import burst_rd_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int BYTE_ENABLE_WIDTH = DEF_BYTE_ENABLE_WIDTH,
    parameter int BURST_WIDTH       = DEF_BURST_WIDTH,
    parameter int LENGTH_WIDTH      = DEF_LENGTH_WIDTH,
    parameter int FIFO_DEPTH        = DEF_FIFO_DEPTH,
    parameter int FIFO_DEPTH_LOG2   = DEF_FIFO_DEPTH_LOG2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    burst_read_wf_if.master          avm,
    input  logic                     ctrl_start,
    input  logic [ADDRESS_WIDTH-1:0] ctrl_baseaddress,
    input  logic [BURST_WIDTH-1:0]   ctrl_burstcount,
    input  logic [LENGTH_WIDTH-1:0]  ctrl_length,
    output logic                     ctrl_busy,
    output logic                     ctrl_done,
    output logic [DATA_WIDTH-1:0]    user_data,
    output logic                     user_valid,
    input  logic                     user_ready
);
    localparam int                      LVL_W    = FIFO_DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0]        LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LENGTH_WIDTH-1:0] LEN_ONE  = {{(LENGTH_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BURST_WIDTH-1:0]  BC_ZERO  = {BURST_WIDTH{1'b0}};

    rd_state_e                state_r, next_state_s;
    logic [ADDRESS_WIDTH-1:0] addr_r, addr_next_s, addr_step_s;
    logic [BURST_WIDTH-1:0]   burst_r, burst_next_s;
    logic [BURST_WIDTH-1:0]   bcount_r, bcount_next_s;
    logic [BURST_WIDTH-1:0]   beat_r, beat_next_s, beats_s;
    logic [LENGTH_WIDTH-1:0]  len_r, len_next_s;
    logic                     read_r, read_next_s;
    logic                     busy_r, busy_next_s;
    logic                     done_r, done_next_s;
    logic                     push_s;
    logic [LVL_W-1:0]         level_s;
    logic [LVL_W-1:0]         free_s;

    assign addr_step_s = ADDRESS_WIDTH'(addr_incr(32'(burst_r), 32'(BYTE_ENABLE_WIDTH)));
    assign free_s      = LVL_FULL - level_s;

    // Next-state and next-register logic for the request sequencer.
    always_comb begin
        next_state_s  = state_r;
        addr_next_s   = addr_r;
        burst_next_s  = burst_r;
        bcount_next_s = bcount_r;
        beat_next_s   = beat_r;
        len_next_s    = len_r;
        read_next_s   = read_r;
        busy_next_s   = busy_r;
        done_next_s   = 1'b0;
        push_s        = 1'b0;
        beats_s       = beat_r;
        case (state_r)
            IDLE: begin
                if (ctrl_start) begin
                    addr_next_s  = ctrl_baseaddress;
                    burst_next_s = ctrl_burstcount;
                    len_next_s   = ctrl_length;
                    busy_next_s  = 1'b1;
                    if ((ctrl_burstcount == BC_ZERO) || (ctrl_length == {LENGTH_WIDTH{1'b0}})) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = CHECK;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            CHECK: begin
                if (free_s >= LVL_W'(burst_r)) begin
                    read_next_s   = 1'b1;
                    bcount_next_s = burst_r;
                    next_state_s  = REQ;
                end else begin
                    next_state_s = CHECK;
                end
            end
            REQ: begin
                // A beat may return in the very cycle the request is accepted.
                if (!avm.master_waitrequest) begin
                    read_next_s  = 1'b0;
                    push_s       = avm.master_readdatavalid;
                    beats_s      = {{(BURST_WIDTH-1){1'b0}}, push_s};
                    beat_next_s  = beats_s;
                    next_state_s = DATA;
                end else begin
                    read_next_s = 1'b1;
                end
            end
            DATA: begin
                push_s      = avm.master_readdatavalid;
                beats_s     = beat_r + {{(BURST_WIDTH-1){1'b0}}, push_s};
                beat_next_s = beats_s;
            end
            DONE: begin
                busy_next_s  = 1'b0;
                done_next_s  = 1'b1;
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
        if (push_s && (beats_s == burst_r)) begin
            beat_next_s = BC_ZERO;
            len_next_s  = len_r - LEN_ONE;
            addr_next_s = addr_r + addr_step_s;
            if (len_r == LEN_ONE) begin
                next_state_s = DONE;
            end else begin
                next_state_s = CHECK;
            end
        end else begin
            len_next_s = len_next_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            addr_r   <= {ADDRESS_WIDTH{1'b0}};
            burst_r  <= BC_ZERO;
            bcount_r <= BC_ZERO;
            beat_r   <= BC_ZERO;
            len_r    <= {LENGTH_WIDTH{1'b0}};
            read_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            addr_r   <= addr_next_s;
            burst_r  <= burst_next_s;
            bcount_r <= bcount_next_s;
            beat_r   <= beat_next_s;
            len_r    <= len_next_s;
            read_r   <= read_next_s;
            busy_r   <= busy_next_s;
            done_r   <= done_next_s;
        end
    end

    burst_rd_fifo #(
        .WIDTH      (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data (avm.master_readdata),
        .pop       (user_ready),
        .head_data (user_data),
        .not_empty (user_valid),
        .level     (level_s)
    );

    assign avm.master_address    = addr_r;
    assign avm.master_read       = read_r;
    assign avm.master_burstcount = bcount_r;
    assign avm.master_byteenable = {BYTE_ENABLE_WIDTH{1'b1}};
    assign ctrl_busy             = busy_r;
    assign ctrl_done             = done_r;

endmodule

// File: tb/tb_burst_read_wf.sv
// Self-checking bench for burst_read_wf: a randomised Avalon slave and stream consumer,
// with expectations (burst addresses, word order, done pulse) derived from operation parameters.
module tb_burst_read_wf;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_start = 1'b0;
    logic [31:0] ctrl_baseaddress = 32'd0;
    logic [3:0]  ctrl_burstcount = 4'd0;
    logic [15:0] ctrl_length = 16'd0;
    logic        ctrl_busy, ctrl_done;
    logic [31:0] user_data;
    logic        user_valid;
    logic        user_ready;

    always #5 clk = ~clk;

    burst_read_wf_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .BYTE_ENABLE_WIDTH(4), .BURST_WIDTH(4)) bus ();

    burst_read_wf #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .BYTE_ENABLE_WIDTH(4), .BURST_WIDTH(4),
        .LENGTH_WIDTH(16), .FIFO_DEPTH(16), .FIFO_DEPTH_LOG2(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .avm(bus),
        .ctrl_start(ctrl_start), .ctrl_baseaddress(ctrl_baseaddress),
        .ctrl_burstcount(ctrl_burstcount), .ctrl_length(ctrl_length),
        .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done),
        .user_data(user_data), .user_valid(user_valid), .user_ready(user_ready)
    );

    int pass_cnt = 0;
    int check_cnt = 0;
    int cyc = 0;
    int wait_prob = 0, ready_prob = 100, rdv_prob = 100, force_wait = 0;
    logic [31:0] cur_base = 32'd0, data_off = 32'd0;
    logic [31:0] pend_q[$];
    logic [31:0] got_q[$];
    logic [31:0] req_addr_q[$];
    logic [3:0]  req_bc_q[$];
    int done_cnt = 0, done_cyc = 0, done_busy_bad = 0, read_cycles = 0, accepts = 0;
    int first_rdv_cyc = -1, first_valid_cyc = -1, start_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic [3:0]  prev_bc = 4'd0;

    typedef struct {
        logic [31:0] base;
        logic [3:0]  bc;
        logic [15:0] len;
        int          wait_p;
        int          ready_p;
        int          rdv_p;
        int          exp_bursts;
        int          exp_words;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer, memory slave and monitors, all acting on the falling edge.
    always @(negedge clk) begin
        logic stall;
        logic [31:0] a;
        user_ready = ($urandom_range(99) < ready_prob);
        if (user_valid && user_ready) got_q.push_back(user_data);
        if (user_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (ctrl_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (ctrl_busy) done_busy_bad++;
        end
        if (bus.master_read) begin
            read_cycles++;
            a = bus.master_address;
            if (prev_stall) begin
                check("req_addr_stable", a, prev_addr);
                check("req_bc_stable", bus.master_burstcount, prev_bc);
            end
            stall = (force_wait > 0) || ($urandom_range(99) < wait_prob);
            if (force_wait > 0) force_wait--;
            bus.master_waitrequest = stall;
            if (!stall) begin
                accepts++;
                req_addr_q.push_back(a);
                req_bc_q.push_back(bus.master_burstcount);
                for (int i = 0; i < int'(bus.master_burstcount); i++)
                    pend_q.push_back(data_off + ((a - cur_base) >> 2) + 32'(i));
            end
            prev_stall = stall;
            prev_addr  = a;
            prev_bc    = bus.master_burstcount;
        end else begin
            bus.master_waitrequest = 1'($urandom_range(1));
            prev_stall = 1'b0;
        end
        if (pend_q.size() > 0 && $urandom_range(99) < rdv_prob) begin
            bus.master_readdatavalid = 1'b1;
            bus.master_readdata = pend_q.pop_front();
            if (first_rdv_cyc < 0) first_rdv_cyc = cyc;
        end else begin
            bus.master_readdatavalid = 1'b0;
            bus.master_readdata = $urandom;
        end
    end

    task automatic start_op(input logic [31:0] base, input logic [3:0] bc,
                            input logic [15:0] len, input logic [31:0] off);
        @(negedge clk); #1;
        got_q.delete(); req_addr_q.delete(); req_bc_q.delete();
        done_cnt = 0; done_busy_bad = 0; read_cycles = 0; accepts = 0;
        first_rdv_cyc = -1; first_valid_cyc = -1;
        cur_base = base; data_off = off;
        ctrl_start = 1'b1; ctrl_baseaddress = base; ctrl_burstcount = bc; ctrl_length = len;
        start_cyc = cyc;
        @(negedge clk); #1;
        ctrl_start = 1'b0;
        check("busy_after_start", ctrl_busy, 1'b1);
    endtask

    task automatic finish_op(input string tag, input logic [31:0] base, input logic [3:0] bc,
                             input logic [15:0] len, input logic [31:0] off);
        int n_b, n_w, guard;
        logic [31:0] ea;
        n_b = (bc == 4'd0 || len == 16'd0) ? 0 : int'(len);
        n_w = n_b * int'(bc);
        guard = 0;
        while ((done_cnt == 0 || got_q.size() < n_w) && guard < 4000) begin
            @(negedge clk); guard++;
        end
        check({tag, ".no_timeout"}, guard < 4000, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        check({tag, ".done_pulses"}, done_cnt, 1);
        check({tag, ".busy_at_done"}, done_busy_bad, 0);
        check({tag, ".busy_end"}, ctrl_busy, 1'b0);
        check({tag, ".valid_end"}, user_valid, 1'b0);
        check({tag, ".accepts"}, accepts, n_b);
        check({tag, ".words"}, got_q.size(), n_w);
        for (int i = 0; i < n_b && i < req_addr_q.size(); i++) begin
            ea = base + 32'(i) * 32'(bc) * 32'd4;
            check($sformatf("%s.burst%0d_addr", tag, i), req_addr_q[i], ea);
            check($sformatf("%s.burst%0d_bc", tag, i), req_bc_q[i], bc);
        end
        for (int k = 0; k < n_w && k < got_q.size(); k++)
            check($sformatf("%s.word%0d", tag, k), got_q[k], off + 32'(k));
    endtask

    initial begin
        vec_t vecs[7];
        logic [31:0] off;
        int guard;
        vecs[0] = '{32'h3800_0000, 4'd8, 16'd1,  0, 100, 100, 1,  8};
        vecs[1] = '{32'h0000_0100, 4'd4, 16'd3,  0, 100, 100, 3, 12};
        vecs[2] = '{32'hFFFF_FFF0, 4'd4, 16'd2, 30,  60,  70, 2,  8};
        vecs[3] = '{32'h0000_1000, 4'd1, 16'd5, 20,  80,  50, 5,  5};
        vecs[4] = '{32'h0000_2000, 4'd0, 16'd3,  0, 100, 100, 0,  0};
        vecs[5] = '{32'h0000_3000, 4'd5, 16'd0,  0, 100, 100, 0,  0};
        vecs[6] = '{32'h0000_0040, 4'd8, 16'd4, 10,  30,  80, 4, 32};

        repeat (3) @(negedge clk);
        #1;
        check("rst.address", bus.master_address, 32'd0);
        check("rst.read", bus.master_read, 1'b0);
        check("rst.burstcount", bus.master_burstcount, 4'd0);
        check("rst.byteenable", bus.master_byteenable, 4'hF);
        check("rst.busy", ctrl_busy, 1'b0);
        check("rst.done", ctrl_done, 1'b0);
        check("rst.valid", user_valid, 1'b0);
        reset_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            wait_prob = vecs[v].wait_p; ready_prob = vecs[v].ready_p; rdv_prob = vecs[v].rdv_p;
            off = (v == 0) ? 32'd3 : $urandom;
            start_op(vecs[v].base, vecs[v].bc, vecs[v].len, off);
            finish_op($sformatf("vec%0d", v), vecs[v].base, vecs[v].bc, vecs[v].len, off);
            check($sformatf("vec%0d.bursts", v), accepts, vecs[v].exp_bursts);
            check($sformatf("vec%0d.nwords", v), got_q.size(), vecs[v].exp_words);
            if (vecs[v].exp_bursts == 0) begin
                check($sformatf("vec%0d.no_read", v), read_cycles, 0);
                check($sformatf("vec%0d.done_delay", v), done_cyc - start_cyc, 2);
            end else begin
                check($sformatf("vec%0d.valid_latency", v), first_valid_cyc - first_rdv_cyc, 1);
            end
        end

        // Waitrequest held for five cycles: request must stay put, then be accepted once.
        wait_prob = 0; ready_prob = 100; rdv_prob = 100; force_wait = 5;
        start_op(32'h0000_5000, 4'd4, 16'd1, 32'h11);
        finish_op("stall", 32'h0000_5000, 4'd4, 16'd1, 32'h11);
        check("stall.read_cycles", read_cycles, 6);

        // Consumer stalled: two bursts fill the FIFO, the third waits for room.
        ready_prob = 0; rdv_prob = 100;
        start_op(32'h0000_8000, 4'd8, 16'd3, 32'h200);
        repeat (10) @(negedge clk);
        #1;
        ctrl_start = 1'b1; ctrl_baseaddress = 32'hDEAD_0000; ctrl_burstcount = 4'd2; ctrl_length = 16'd7;
        @(negedge clk); #1;
        ctrl_start = 1'b0;
        repeat (60) @(negedge clk);
        #1;
        check("bp.accepts_held", accepts, 2);
        check("bp.busy_held", ctrl_busy, 1'b1);
        check("bp.nothing_popped", got_q.size(), 0);
        ready_prob = 100;
        finish_op("bp", 32'h0000_8000, 4'd8, 16'd3, 32'h200);

        // Reset while a burst is returning data; late beats must be ignored.
        rdv_prob = 40;
        start_op(32'h0000_9000, 4'd8, 16'd2, 32'h300);
        guard = 0;
        while (first_rdv_cyc < 0 && guard < 200) begin @(negedge clk); guard++; end
        check("rstmid.saw_data", guard < 200, 1'b1);
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("rstmid.address", bus.master_address, 32'd0);
        check("rstmid.read", bus.master_read, 1'b0);
        check("rstmid.burstcount", bus.master_burstcount, 4'd0);
        check("rstmid.busy", ctrl_busy, 1'b0);
        check("rstmid.done", ctrl_done, 1'b0);
        check("rstmid.valid", user_valid, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b1;
        rdv_prob = 100;
        guard = 0;
        while (pend_q.size() > 0 && guard < 200) begin @(negedge clk); guard++; end
        repeat (3) @(negedge clk);
        #1;
        check("rstmid.late_dropped", user_valid, 1'b0);
        check("rstmid.idle_busy", ctrl_busy, 1'b0);
        start_op(32'h0000_A000, 4'd4, 16'd2, 32'h400);
        finish_op("after_rst", 32'h0000_A000, 4'd4, 16'd2, 32'h400);

        // Randomised operations against the arithmetic model.
        for (int r = 0; r < 8; r++) begin
            logic [31:0] b;
            logic [3:0]  bc;
            logic [15:0] ln;
            b  = $urandom;
            bc = 4'($urandom_range(8, 1));
            ln = 16'($urandom_range(4, 1));
            wait_prob = $urandom_range(50); ready_prob = $urandom_range(100, 20);
            rdv_prob = $urandom_range(100, 30);
            off = $urandom;
            start_op(b, bc, ln, off);
            finish_op($sformatf("rnd%0d", r), b, bc, ln, off);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
